// File: rtl/pc_gen.sv
// Program-counter / fetch-address generator for the IF stage.
// Issues fetch addresses over valid/ready, steps sequentially and follows trap/jump/branch redirects.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'('h100),
  parameter int              INSN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_valid,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] addr,
  output logic            misalign,
  output logic            halted
);

  localparam int              ALIGN_BITS = $clog2(INSN_BYTES);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_d;
  logic            valid_d;
  logic            misalign_d;
  logic            halted_d;

  logic            fire;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            target_aligned;

  // Jump outranks branch when both request a redirect in the same cycle.
  assign redirect        = jmp_valid | br_taken;
  assign redirect_target = jmp_valid ? jmp_target : br_target;
  assign target_aligned  = (redirect_target[ALIGN_BITS-1:0] == '0);
  assign fire            = if_valid & if_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr;
    valid_d    = if_valid;
    misalign_d = misalign;

    unique case (state_q)
      S_BOOT: begin
        if (trap_valid) addr_d = TRAP_VEC;
        valid_d = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (trap_valid) begin
          addr_d  = TRAP_VEC;
          valid_d = 1'b1;
        end else if (redirect) begin
          addr_d = redirect_target;
          if (target_aligned) begin
            valid_d = 1'b1;
          end else begin
            valid_d    = 1'b0;
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end
        end else if (fire && !stall) begin
          addr_d = addr + STEP;
        end
      end

      S_HALT: begin
        valid_d = 1'b0;
        if (trap_valid) begin
          addr_d     = TRAP_VEC;
          valid_d    = 1'b1;
          misalign_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      default: begin
        addr_d     = RESET_VEC;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        state_d    = S_BOOT;
      end
    endcase

    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      addr     <= RESET_VEC;
      if_valid <= 1'b0;
      misalign <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr     <= addr_d;
      if_valid <= valid_d;
      misalign <= misalign_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand sequences and random stimulus
// checked against a behavioural model, on a 4-byte and a 2-byte build.
module tb_pc_gen;

  localparam logic [31:0] RST_V  = 32'h0;
  localparam logic [31:0] TRAP_V = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp_valid, trap_valid, if_ready;
  logic [31:0] br_target, jmp_target;

  logic        v4, m4, h4, v2, m2, h2;
  logic [31:0] a4, a2;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V), .INSN_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .trap_valid(trap_valid), .if_ready(if_ready),
    .if_valid(v4), .addr(a4), .misalign(m4), .halted(h4)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V), .INSN_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .trap_valid(trap_valid), .if_ready(if_ready),
    .if_valid(v2), .addr(a2), .misalign(m2), .halted(h2)
  );

  // ---------------- behavioural reference model ----------------
  localparam int PH_BOOT = 0, PH_RUN = 1, PH_HALT = 2;

  typedef struct {
    int          phase;
    logic [31:0] addr;
    bit          valid;
    bit          mis;
  } model_t;

  model_t mdl4, mdl2;

  function automatic model_t model_step(model_t m, int ib);
    model_t   n = m;
    longint   tgt;
    if (rst) begin
      n.phase = PH_BOOT; n.addr = RST_V; n.valid = 0; n.mis = 0;
      return n;
    end
    if (m.phase == PH_BOOT) begin
      if (trap_valid) n.addr = TRAP_V;
      n.valid = 1; n.phase = PH_RUN;
    end else if (m.phase == PH_HALT) begin
      n.valid = 0;
      if (trap_valid) begin
        n.addr = TRAP_V; n.valid = 1; n.mis = 0; n.phase = PH_RUN;
      end
    end else if (trap_valid) begin
      n.addr = TRAP_V; n.valid = 1;
    end else if (jmp_valid || br_taken) begin
      tgt = jmp_valid ? longint'(jmp_target) : longint'(br_target);
      n.addr = tgt[31:0];
      if (tgt % ib == 0) n.valid = 1;
      else begin n.valid = 0; n.mis = 1; n.phase = PH_HALT; end
    end else if (m.valid && if_ready && !stall) begin
      tgt = (longint'(m.addr) + ib) % 64'h1_0000_0000;
      n.addr = tgt[31:0];
    end
    return n;
  endfunction

  function automatic logic [34:0] pack_model(model_t m);
    return {m.valid, m.mis, (m.phase == PH_HALT), m.addr};
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got v/m/h/addr=%b%b%b/%h expected %b%b%b/%h (t=%0t)",
               name, got[34], got[33], got[32], got[31:0],
               exp[34], exp[33], exp[32], exp[31:0], $time);
    end
  endtask

  // One clock: models advance on the same edge, outputs sampled 1 time unit later.
  task automatic tick(input bit check_model4);
    @(posedge clk);
    mdl4 = model_step(mdl4, 4);
    mdl2 = model_step(mdl2, 2);
    #1;
    check("model_ib2", {v2, m2, h2, a2}, pack_model(mdl2));
    if (check_model4) check("model_ib4", {v4, m4, h4, a4}, pack_model(mdl4));
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; br_taken = 0; jmp_valid = 0; trap_valid = 0; if_ready = 0;
    br_target = '0; jmp_target = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        trap, rdy;
    logic        v;
    logic [31:0] a;
    logic        m, h;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic t, logic rd,
                              logic v, logic [31:0] a, logic m, logic h);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.bt = bt; x.jmp = j; x.jt = jt;
    x.trap = t; x.rdy = rd; x.v = v; x.a = a; x.m = m; x.h = h;
    return x;
  endfunction

  initial begin
    // rst stall br bt jmp jt trap rdy | v addr m h   (expectations for the 4-byte build)
    tbl[0]  = mk(1,0,0,0,0,0,0,1, 0,32'h0,0,0);
    tbl[1]  = mk(1,0,0,0,0,0,0,1, 0,32'h0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,1, 1,32'h0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,1, 1,32'h4,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,0,1, 1,32'h8,0,0);
    tbl[5]  = mk(0,0,0,0,0,0,0,0, 1,32'h8,0,0);
    tbl[6]  = mk(0,0,0,0,0,0,0,0, 1,32'h8,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,0,0, 1,32'h8,0,0);
    tbl[8]  = mk(0,1,0,0,0,0,0,1, 1,32'h8,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,1, 1,32'hC,0,0);
    tbl[10] = mk(0,0,1,32'h40,1,32'h80,0,1, 1,32'h80,0,0);
    tbl[11] = mk(0,0,1,32'h40,1,32'h80,1,1, 1,32'h100,0,0);
    tbl[12] = mk(0,0,0,0,0,0,0,1, 1,32'h104,0,0);
    tbl[13] = mk(0,0,0,0,1,32'h42,0,1, 0,32'h42,1,1);
    tbl[14] = mk(0,0,1,32'h40,0,0,0,1, 0,32'h42,1,1);
    tbl[15] = mk(0,1,0,0,1,32'h80,0,1, 0,32'h42,1,1);
    tbl[16] = mk(0,0,0,0,0,0,1,1, 1,32'h100,0,0);
    tbl[17] = mk(0,0,0,0,0,0,0,1, 1,32'h104,0,0);
    tbl[18] = mk(0,0,0,0,1,32'hFFFF_FFFC,0,1, 1,32'hFFFF_FFFC,0,0);
    tbl[19] = mk(0,0,0,0,0,0,0,1, 1,32'h0,0,0);
    tbl[20] = mk(0,0,0,0,0,0,0,1, 1,32'h4,0,0);
    tbl[21] = mk(0,0,0,0,1,32'h43,0,1, 0,32'h43,1,1);
    tbl[22] = mk(1,0,0,0,0,0,0,1, 0,32'h0,0,0);
    tbl[23] = mk(0,0,0,0,0,0,1,1, 1,32'h100,0,0);
    tbl[24] = mk(0,0,0,0,0,0,0,0, 1,32'h100,0,0);

    idle_inputs();
    mdl4 = '{PH_BOOT, RST_V, 0, 0};
    mdl2 = '{PH_BOOT, RST_V, 0, 0};

    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].bt;
      jmp_valid = tbl[i].jmp; jmp_target = tbl[i].jt; trap_valid = tbl[i].trap;
      if_ready = tbl[i].rdy;
      tick(0);
      check($sformatf("vec%0d", i), {v4, m4, h4, a4}, {tbl[i].v, tbl[i].m, tbl[i].h, tbl[i].a});
    end

    // Hand sequence: 2-byte build steps by 2 and traps on an odd branch target.
    idle_inputs(); rst = 1; if_ready = 1;
    tick(1);
    rst = 0;
    tick(1);
    check("ib2_boot", {v2, m2, h2, a2}, {3'b100, 32'h0});
    tick(1);
    check("ib2_step", {v2, m2, h2, a2}, {3'b100, 32'h2});
    br_taken = 1; br_target = 32'h41;
    tick(1);
    check("ib2_misalign", {v2, m2, h2, a2}, {3'b011, 32'h41});
    br_target = 32'h40;
    tick(1);
    check("ib2_halt_ignores_br", {v2, m2, h2, a2}, {3'b011, 32'h41});
    br_taken = 0; trap_valid = 1;
    tick(1);
    check("ib2_trap_exit", {v2, m2, h2, a2}, {3'b100, TRAP_V});
    trap_valid = 0;
    tick(1);
    check("ib2_after_trap", {v2, m2, h2, a2}, {3'b100, 32'h102});

    // Random stimulus against the model on both builds.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      rst        = ($urandom_range(99) == 0);
      trap_valid = ($urandom_range(29) == 0);
      jmp_valid  = ($urandom_range(11) == 0);
      br_taken   = ($urandom_range(7) == 0);
      stall      = ($urandom_range(3) == 0);
      if_ready   = ($urandom_range(3) != 0);
      r = $urandom;
      if ($urandom_range(9) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      br_target  = ($urandom_range(5) == 0) ? r : (r & ~32'h3);
      r = $urandom;
      if ($urandom_range(9) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      jmp_target = ($urandom_range(5) == 0) ? r : (r & ~32'h3);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
